// File: rtl/ysyx_bus_arbiter.sv
// Two-master arbiter sharing one AXI4-Lite-style memory port between the IFU (read-only) and the LSU (read/write).
// Optional round-robin arbitration between IFU and LSU is enabled with the YSYX_BUS_ARB_RR_EN macro.
module ysyx_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU read master
    input  logic [ADDR_W-1:0]     i_ifu_araddr,
    input  logic                  i_ifu_arvalid,
    output logic [DATA_W-1:0]     o_ifu_rdata,
    output logic                  o_ifu_rvalid,
    // LSU read/write master
    input  logic [ADDR_W-1:0]     i_lsu_araddr,
    input  logic                  i_lsu_arvalid,
    output logic [DATA_W-1:0]     o_lsu_rdata,
    output logic                  o_lsu_rvalid,
    input  logic [ADDR_W-1:0]     i_lsu_awaddr,
    input  logic                  i_lsu_awvalid,
    input  logic [DATA_W-1:0]     i_lsu_wdata,
    input  logic [DATA_W/8-1:0]   i_lsu_wstrb,
    output logic                  o_lsu_bvalid,
    // Memory port
    output logic [ADDR_W-1:0]     o_mem_araddr,
    output logic                  o_mem_arvalid,
    input  logic                  i_mem_arready,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    input  logic                  i_mem_rvalid,
    output logic                  o_mem_rready,
    output logic [ADDR_W-1:0]     o_mem_awaddr,
    output logic                  o_mem_awvalid,
    input  logic                  i_mem_awready,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_wstrb,
    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    input  logic                  i_mem_bvalid,
    output logic                  o_mem_bready
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IFU_AR = 3'd1,
        S_IFU_R  = 3'd2,
        S_LSU_AR = 3'd3,
        S_LSU_R  = 3'd4,
        S_LSU_W  = 3'd5,
        S_LSU_B  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic                  w_lsu_req;
    logic                  w_lsu_wins;
    logic                  w_grant_wr;
    logic                  w_grant_lrd;
    logic                  w_grant_ifu;

    assign w_lsu_req = i_lsu_awvalid | i_lsu_arvalid;

`ifdef YSYX_BUS_ARB_RR_EN
    // r_last_owner: 1'b0 = IFU, 1'b1 = LSU; on a collision the other master wins
    logic r_last_owner;

    assign w_lsu_wins = w_lsu_req & (~i_ifu_arvalid | ~r_last_owner);

    // Remember which master received the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= 1'b0;
        end else if (w_grant_ifu) begin
            r_last_owner <= 1'b0;
        end else if (w_grant_wr | w_grant_lrd) begin
            r_last_owner <= 1'b1;
        end else begin
            r_last_owner <= r_last_owner;
        end
    end
`else
    assign w_lsu_wins = w_lsu_req;
`endif

    assign w_grant_wr  = (r_state == S_IDLE) & w_lsu_wins & i_lsu_awvalid;
    assign w_grant_lrd = (r_state == S_IDLE) & w_lsu_wins & ~i_lsu_awvalid & i_lsu_arvalid;
    assign w_grant_ifu = (r_state == S_IDLE) & ~w_lsu_wins & i_ifu_arvalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = S_LSU_W;
                end else if (w_grant_lrd) begin
                    w_state_nxt = S_LSU_AR;
                end else if (w_grant_ifu) begin
                    w_state_nxt = S_IFU_AR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IFU_AR: w_state_nxt = i_mem_arready ? S_IFU_R : S_IFU_AR;
            S_IFU_R:  w_state_nxt = i_mem_rvalid  ? S_IDLE  : S_IFU_R;
            S_LSU_AR: w_state_nxt = i_mem_arready ? S_LSU_R : S_LSU_AR;
            S_LSU_R:  w_state_nxt = i_mem_rvalid  ? S_IDLE  : S_LSU_R;
            S_LSU_W: begin
                if ((r_aw_done | i_mem_awready) & (r_w_done | i_mem_wready)) begin
                    w_state_nxt = S_LSU_B;
                end else begin
                    w_state_nxt = S_LSU_W;
                end
            end
            S_LSU_B:  w_state_nxt = i_mem_bvalid ? S_IDLE : S_LSU_B;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted request's address and write payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
            r_wstrb <= {(DATA_W/8){1'b0}};
        end else if (w_grant_wr) begin
            r_addr  <= i_lsu_awaddr;
            r_wdata <= i_lsu_wdata;
            r_wstrb <= i_lsu_wstrb;
        end else if (w_grant_lrd) begin
            r_addr  <= i_lsu_araddr;
        end else if (w_grant_ifu) begin
            r_addr  <= i_ifu_araddr;
        end else begin
            r_addr  <= r_addr;
        end
    end

    // Address/data handshake flags; cleared whenever the write phase is not active
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_LSU_W)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_aw_done <= r_aw_done | i_mem_awready;
            r_w_done  <= r_w_done  | i_mem_wready;
        end
    end

    assign o_mem_araddr  = r_addr;
    assign o_mem_arvalid = (r_state == S_IFU_AR) | (r_state == S_LSU_AR);
    assign o_mem_rready  = (r_state == S_IFU_R)  | (r_state == S_LSU_R);
    assign o_mem_awaddr  = r_addr;
    assign o_mem_awvalid = (r_state == S_LSU_W) & ~r_aw_done;
    assign o_mem_wdata   = r_wdata;
    assign o_mem_wstrb   = r_wstrb;
    assign o_mem_wvalid  = (r_state == S_LSU_W) & ~r_w_done;
    assign o_mem_bready  = (r_state == S_LSU_B);

    // Read data is passed straight through; only the owner sees rvalid
    assign o_ifu_rdata   = i_mem_rdata;
    assign o_lsu_rdata   = i_mem_rdata;
    assign o_ifu_rvalid  = (r_state == S_IFU_R) & i_mem_rvalid;
    assign o_lsu_rvalid  = (r_state == S_LSU_R) & i_mem_rvalid;
    assign o_lsu_bvalid  = (r_state == S_LSU_B) & i_mem_bvalid;

endmodule

// File: doc/ysyx_bus_arbiter.md
Name: ysyx_bus_arbiter

Overview:
- Shares one AXI4-Lite-style memory port between the instruction fetch unit (read-only master) and the load/store unit (read/write master).
- Grants the port to one master per transaction and holds the grant until that transaction's response completes.
- Sits between the IFU/LSU request ports and the SoC memory/crossbar port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_araddr  in  ADDR_W  IFU read address.
- ifu_arvalid  in  1  IFU read request; held high until ifu_rvalid.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rvalid  out  1  IFU read-data valid; 1-cycle pulse.
- lsu_araddr  in  ADDR_W  LSU read address.
- lsu_arvalid  in  1  LSU read request; held high until lsu_rvalid.
- lsu_rdata  out  DATA_W  LSU read data.
- lsu_rvalid  out  1  LSU read-data valid; 1-cycle pulse.
- lsu_awaddr  in  ADDR_W  LSU write address.
- lsu_awvalid  in  1  LSU write request; held high until lsu_bvalid.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wstrb  in  DATA_W/8  LSU byte strobes.
- lsu_bvalid  out  1  LSU write done; 1-cycle pulse.
- mem_araddr/mem_arvalid  out  ADDR_W/1  memory read address channel.
- mem_arready  in  1
- mem_rdata  in  DATA_W
- mem_rvalid  in  1
- mem_rready  out  1
- mem_awaddr/mem_awvalid  out  ADDR_W/1  memory write address channel.
- mem_awready  in  1
- mem_wdata/mem_wstrb/mem_wvalid  out  DATA_W/DATA_W/8/1  memory write data channel.
- mem_wready  in  1
- mem_bvalid  in  1
- mem_bready  out  1

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B. One transaction in flight at a time.
- IDLE decision (fixed priority): lsu_awvalid > lsu_arvalid > ifu_arvalid. Targets: LSU_W, LSU_AR, IFU_AR. Address, wdata and wstrb are latched into registers on grant.
- Latency: the request is seen in cycle N; mem_*valid goes high from N+1. All mem_* outputs are driven from registered state and latched values.
- IFU_AR/LSU_AR: mem_arvalid=1 with the latched address. On mem_arready, go to the matching _R state.
- IFU_R/LSU_R: mem_rready=1.
  - On mem_rvalid, the owner's rvalid=1 in the same cycle, with rdata = mem_rdata passed through combinationally. Then go to IDLE.
  - The non-owner rvalid stays 0. rdata outputs are don't-care when rvalid=0.
- LSU_W: mem_awvalid and mem_wvalid both asserted.
  - Each drops independently once its ready is seen, tracked by two done flags.
  - When both are done (same or different cycles), go to LSU_B.
- LSU_B: mem_bready=1. On mem_bvalid, lsu_bvalid=1 in the same cycle, then go to IDLE.
- IDLE→IDLE: a master's request still high in the cycle after its response pulse is treated as a new transaction. Masters must drop the request in the response cycle if they are done.
- Request changes after grant are ignored until the state returns to IDLE.
- Reset, including mid-transaction: state=IDLE, done flags=0, latched regs=0. All outputs 0: mem_*valid, mem_rready, mem_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid. Downstream must be reset in the same cycle.
- No timeouts. The arbiter waits indefinitely on mem ready/valid.

Optional Feature:
- Macro: YSYX_BUS_ARB_RR_EN.
- Defined:
  - A last_owner register, reset to IFU, is updated on every grant.
  - When IFU and LSU requests collide in IDLE, the master not granted last wins. Within the LSU, write still beats read.
- Undefined: fixed priority as above. The IFU can starve under continuous LSU traffic.

Test Plan:
- IFU read alone: ifu_araddr=0x8000_0000, mem_arready in cycle 2, mem_rvalid with 0x0000_0413 in cycle 4 → mem_arvalid high cycles 1–2; ifu_rvalid=1 and ifu_rdata=0x0000_0413 in cycle 4 only; lsu_rvalid=0 throughout.
- Collision: ifu_arvalid and lsu_arvalid rise together, lsu_araddr=0x8000_1000 → first mem_araddr=0x8000_1000. IFU is served next, with mem_araddr equal to the IFU address.
- LSU write, split handshake: awaddr=0x8000_2000, wdata=0xDEAD_BEEF, wstrb=0xF; awready in cycle 1, wready in cycle 3, bvalid in cycle 5 → mem_awvalid drops after cycle 1; mem_wvalid held until cycle 3; lsu_bvalid pulse in cycle 5.
- Write-over-read priority: lsu_awvalid, lsu_arvalid and ifu_arvalid all high → service order write, LSU read, IFU read; exactly one response pulse each.
- Reset during IFU_R: rst asserted for 1 cycle → next cycle all valid/ready outputs 0 and state IDLE. A new ifu_arvalid is then served normally.
- With YSYX_BUS_ARB_RR_EN: IFU and LSU reads both held continuously → grants alternate LSU, IFU, LSU, IFU.
